// File: rtl/sg_pkg.sv
// Shared definitions for the segment-benchmark observers: monitor state
// encoding and the default sizing constants used by sg_idle_monitor.
package sg_pkg;

  typedef enum logic [1:0] {
    HOME  = 2'd0,
    AWAY  = 2'd1,
    STUCK = 2'd2
  } MonStates;

  localparam int SG_STALL_LIMIT = 4;
  localparam int SG_CNT_W       = 3;
  localparam int SG_EXC_W       = 4;

endpackage

// File: rtl/sg_sat_counter.sv
// Saturating up-counter: holds at all-ones, clr wins over inc, and the
// synchronous reset wins over both.
module sg_sat_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sg_idle_monitor.sv
// Idle monitor: watches the upstream home-state flag, measures how long each
// excursion away from home lasts, flags a stall once an excursion reaches
// STALL_LIMIT cycles, and counts excursions. Every output comes from a flop.
// Optional build macro SG_MON_STICKY_STALL_EN makes stall hold from the first
// entry to STUCK until reset.
module sg_idle_monitor #(
  parameter int STALL_LIMIT = sg_pkg::SG_STALL_LIMIT,
  parameter int CNT_W       = sg_pkg::SG_CNT_W,
  parameter int EXC_W       = sg_pkg::SG_EXC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idle,
  output logic             busy,
  output logic             stall,
  output logic [CNT_W-1:0] run_len,
  output logic [EXC_W-1:0] excursions,
  output logic             ret_pulse
);

  import sg_pkg::*;

  localparam int RUN_MAX_INT         = (2 ** CNT_W) - 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};

  // A limit of zero or beyond what run_len can represent could never be met.
  if ((STALL_LIMIT < 1) || (STALL_LIMIT > RUN_MAX_INT)) begin : g_bad_limit
    $error("sg_idle_monitor: STALL_LIMIT out of range 1..2^CNT_W-1");
  end

  MonStates         state_q;
  MonStates         state_d;
  logic             busy_q;
  logic             busy_d;
  logic             stall_q;
  logic             stall_d;
  logic             ret_pulse_q;
  logic             ret_pulse_d;
  logic [CNT_W-1:0] run_next;
  logic             exc_inc;

  // run_len restarts on every home sample and grows on every away sample;
  // while HOME it is always zero, so the first away sample yields 1.
  sg_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (idle),
    .inc   (~idle),
    .q     (run_len)
  );

  // Excursions are counted on the HOME->away edge and cleared only by reset.
  sg_sat_counter #(.W(EXC_W)) u_exc_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (exc_inc),
    .q     (excursions)
  );

  // Next-state logic and next values of the flag outputs.
  always_comb begin
    state_d     = state_q;
    run_next    = (run_len == RUN_MAX) ? run_len : run_len + CNT_W'(1);
    exc_inc     = (state_q == HOME) && !idle;
    case (state_q)
      HOME: begin
        if (!idle) begin
          state_d = (STALL_LIMIT == 1) ? STUCK : AWAY;
        end
      end
      AWAY: begin
        if (idle) begin
          state_d = HOME;
        end else if (run_next >= LIMIT) begin
          state_d = STUCK;
        end
      end
      STUCK: begin
        if (idle) begin
          state_d = HOME;
        end
      end
      default: begin
        state_d = HOME;
      end
    endcase
    busy_d      = (state_d != HOME);
    ret_pulse_d = (state_q != HOME) && idle;
`ifdef SG_MON_STICKY_STALL_EN
    stall_d     = stall_q || (state_d == STUCK);
`else
    stall_d     = (state_d == STUCK);
`endif
  end

  // State and output flag registers; reset discards any excursion in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOME;
      busy_q      <= 1'b0;
      stall_q     <= 1'b0;
      ret_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      ret_pulse_q <= ret_pulse_d;
    end
  end

  assign busy      = busy_q;
  assign stall     = stall_q;
  assign ret_pulse = ret_pulse_q;

endmodule

// File: tb/tb_sg_idle_monitor.sv
// Directed bench for sg_idle_monitor with hand-computed expectations.
// Stall expectations after a return home follow SG_MON_STICKY_STALL_EN.
module tb_sg_idle_monitor;

  localparam int CNT_W = 3;
  localparam int EXC_W = 4;
  localparam int LIMIT = 4;
`ifdef SG_MON_STICKY_STALL_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             idle;
  logic             busy;
  logic             stall;
  logic [CNT_W-1:0] run_len;
  logic [EXC_W-1:0] excursions;
  logic             ret_pulse;

  int testsRun  = 0;
  int testsFail = 0;
  int retCount  = 0;

  sg_idle_monitor #(
    .STALL_LIMIT (LIMIT),
    .CNT_W       (CNT_W),
    .EXC_W       (EXC_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .idle       (idle),
    .busy       (busy),
    .stall      (stall),
    .run_len    (run_len),
    .excursions (excursions),
    .ret_pulse  (ret_pulse)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive inputs, take one rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input logic rstVal, input logic idleVal);
    reset = rstVal;
    idle  = idleVal;
    @(posedge clock);
    #1;
  endtask

  // Compare every output against the expected tuple.
  task automatic checkOutput(input string tag, input logic expBusy,
                             input logic expStall, input logic [CNT_W-1:0] expRun,
                             input logic [EXC_W-1:0] expExc, input logic expRet);
    testsRun++;
    assert (busy === expBusy) else begin
      testsFail++;
      $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, expBusy);
    end
    testsRun++;
    assert (stall === expStall) else begin
      testsFail++;
      $error("[TB] FAIL %s stall: observed %b expected %b", tag, stall, expStall);
    end
    testsRun++;
    assert (run_len === expRun) else begin
      testsFail++;
      $error("[TB] FAIL %s run_len: observed %0d expected %0d", tag, run_len, expRun);
    end
    testsRun++;
    assert (excursions === expExc) else begin
      testsFail++;
      $error("[TB] FAIL %s excursions: observed %0d expected %0d", tag, excursions, expExc);
    end
    testsRun++;
    assert (ret_pulse === expRet) else begin
      testsFail++;
      $error("[TB] FAIL %s ret_pulse: observed %b expected %b", tag, ret_pulse, expRet);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle  = 1'b0;

    // Scenario 1: reset held two cycles with idle=0, then release with idle=0.
    applyStimulus(1'b1, 1'b0);
    checkOutput("s1_rst1", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s1_rst2", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("s1_rel", 1'b1, 1'b0, 3'd1, 4'd1, 1'b0);

    // Scenario 2: short excursion, idle 1,0,0,1,1.
    applyStimulus(1'b1, 1'b1);
    checkOutput("s2_rst", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s2_c1", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("s2_c2", 1'b1, 1'b0, 3'd1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("s2_c3", 1'b1, 1'b0, 3'd2, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s2_c4", 1'b0, 1'b0, 3'd0, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s2_c5", 1'b0, 1'b0, 3'd0, 4'd1, 1'b0);

    // Scenario 3: ten away cycles, run_len saturates, stall from run_len=4.
    applyStimulus(1'b1, 1'b1);
    checkOutput("s3_rst", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("s3_away%0d", k), 1'b1, (k >= LIMIT),
                  (k > 7) ? 3'd7 : 3'(k), 4'd1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("s3_ret", 1'b0, STICKY, 3'd0, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s3_home", 1'b0, STICKY, 3'd0, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("s3_clr", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

    // Scenario 4: 17 one-cycle excursions; excursion count saturates at 15.
    retCount = 0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("s4_out%0d", i), 1'b1, 1'b0, 3'd1,
                  (i > 15) ? 4'd15 : 4'(i), 1'b0);
      applyStimulus(1'b0, 1'b1);
      if (ret_pulse === 1'b1) retCount++;
      checkOutput($sformatf("s4_back%0d", i), 1'b0, 1'b0, 3'd0,
                  (i > 15) ? 4'd15 : 4'(i), 1'b1);
    end
    testsRun++;
    assert (retCount === 17) else begin
      testsFail++;
      $error("[TB] FAIL s4_pulses: observed %0d expected 17", retCount);
    end

    // Scenario 5: reset while STUCK abandons the excursion without a pulse.
    applyStimulus(1'b1, 1'b1);
    checkOutput("s5_rst", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("s5_stuck", 1'b1, 1'b1, 3'd5, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("s5_abort", 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("s5_rel", 1'b1, 1'b0, 3'd1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s5_ret", 1'b0, 1'b0, 3'd0, 4'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
